// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_REDIR,
    PC_RET
  } pc_sel_t;

  localparam int unsigned RAS_DEPTH_DEFAULT = 4;
  localparam int unsigned RAS_PTR_W         = $clog2(RAS_DEPTH_DEFAULT);

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the pointer addresses the top entry, and the count saturates at DEPTH.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       replace_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            wdata_i,
  output logic [XLEN-1:0]            top_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ptr_inc = ptr_q + PTR_W'(1);
  assign top_o   = mem_q[ptr_q];
  assign count_o = cnt_q;

  // Flush is applied last so it overrides any push in the same cycle.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_inc;
      cnt_d = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (replace_i && (cnt_q == '0)) begin
      cnt_d = CNT_W'(1);
    end
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset; contents are meaningless while the count is zero.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[ptr_inc] <= wdata_i;
    end else if (replace_i) begin
      mem_q[ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, redirect, and call/return handling through a circular RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         start_i,
  input  logic                         pc_write_i,
  input  logic                         redirect_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  input  logic                         flush_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [XLEN-1:0]              pc_plus_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_miss_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             miss_q, miss_d;
  logic [XLEN-1:0]  ras_top;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_hit;
  logic             push, pop, repl;
  pc_sel_t          sel;

  assign pc_plus_o   = pc_q + XLEN'(STEP);
  assign pc_o        = pc_q;
  assign ras_miss_o  = miss_q;
  assign ras_count_o = ras_cnt;
  assign ras_hit     = (ras_cnt != '0);

  // A call together with a return swaps the top entry instead of pushing or popping.
  assign push = pc_write_i &  call_i & ~ret_i;
  assign pop  = pc_write_i & ~call_i &  ret_i & ras_hit;
  assign repl = pc_write_i &  call_i &  ret_i;

  always_comb begin
    sel    = PC_SEQ;
    pc_d   = pc_q;
    miss_d = 1'b0;
    if (!pc_write_i)               sel = PC_HOLD;
    else if (ret_i)                sel = PC_RET;
    else if (call_i || redirect_i) sel = PC_REDIR;
    case (sel)
      PC_HOLD:  pc_d = pc_q;
      PC_SEQ:   pc_d = pc_plus_o;
      PC_REDIR: pc_d = redirect_pc_i;
      PC_RET: begin
        pc_d   = ras_hit ? ras_top : redirect_pc_i;
        miss_d = ~ras_hit;
      end
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      pc_q   <= RESET_PC;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= miss_d;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i     (clk_i),
    .rst_ni    (start_i),
    .push_i    (push),
    .pop_i     (pop),
    .replace_i (repl),
    .flush_i   (flush_i),
    .wdata_i   (pc_plus_o),
    .top_o     (ras_top),
    .count_o   (ras_cnt)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: queue-based reference model feeds expectations to an independent monitor.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        start_i;
  logic        pc_write_i, redirect_i, call_i, ret_i, flush_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, pc_plus_o;
  logic [2:0]  ras_count_o;
  logic        ras_miss_o;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i         (clk),
    .start_i       (start_i),
    .pc_write_i    (pc_write_i),
    .redirect_i    (redirect_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .redirect_pc_i (redirect_pc_i),
    .flush_i       (flush_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .ras_count_o   (ras_count_o),
    .ras_miss_o    (ras_miss_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        miss;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        st_nxt;
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic pw, input logic red, input logic call, input logic ret,
                      input logic flush, input logic [31:0] rpc);
    exp_t        e;
    logic [31:0] npc;
    logic        miss;
    @(negedge clk);
    start_i = st_nxt; pc_write_i = pw; redirect_i = red; call_i = call;
    ret_i = ret; flush_i = flush; redirect_pc_i = rpc;
    miss = 1'b0;
    if (!st_nxt) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else begin
      npc = m_pc;
      if (pw) begin
        if (ret) begin
          if (m_ras.size() > 0) begin
            npc = m_ras[m_ras.size()-1];
            if (call) m_ras[m_ras.size()-1] = m_pc + 32'd4;
            else void'(m_ras.pop_back());
          end else begin
            npc  = rpc;
            miss = 1'b1;
            if (call) m_ras.push_back(m_pc + 32'd4);
          end
        end else if (call) begin
          npc = rpc;
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (red) begin
          npc = rpc;
        end else begin
          npc = m_pc + 32'd4;
        end
      end
      if (flush) m_ras.delete();
      m_pc = npc;
    end
    e.pc   = m_pc;
    e.cnt  = 3'(m_ras.size());
    e.miss = miss;
    exp_q.push_back(e);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: every output sample after a rising edge consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("pc_plus_o", pc_plus_o, e.pc + 32'd4);
        chk("ras_count_o", 32'(ras_count_o), 32'(e.cnt));
        chk("ras_miss_o", 32'(ras_miss_o), 32'(e.miss));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    start_i = 1'b0; pc_write_i = 1'b0; redirect_i = 1'b0; call_i = 1'b0;
    ret_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    m_pc = 32'h0;
    st_nxt = 1'b0;
    step(1, 1, 0, 0, 0, 32'h123);
    step(1, 0, 1, 0, 0, 32'h456);
    st_nxt = 1'b1;
    seq(3);

    // Asynchronous reset in the middle of a cycle must clear state without a clock edge.
    @(posedge clk);
    #3;
    start_i = 1'b0;
    #1;
    chk("async_pc", pc_o, 32'h0);
    chk("async_cnt", 32'(ras_count_o), 32'h0);
    chk("async_miss", 32'(ras_miss_o), 32'h0);
    m_pc = 32'h0;
    m_ras.delete();
    st_nxt = 1'b0;
    step(1, 0, 0, 0, 0, 32'h0);
    st_nxt = 1'b1;
    seq(1);

    // Stall holds the PC even with a redirect pending.
    step(1, 1, 0, 0, 0, 32'h10);
    step(0, 1, 0, 0, 0, 32'h999);
    step(1, 1, 0, 0, 0, 32'h200);
    seq(1);

    // Call, return, return on empty stack.
    step(1, 1, 0, 0, 0, 32'h100);
    step(1, 0, 1, 0, 0, 32'h400);
    step(1, 0, 0, 1, 0, 32'h0);
    step(1, 0, 0, 1, 0, 32'h50);
    seq(1);

    // Nested calls overflowing the stack, then unwinding.
    step(1, 1, 0, 0, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h10);
    step(1, 0, 1, 0, 0, 32'h20);
    step(1, 0, 1, 0, 0, 32'h30);
    step(1, 0, 1, 0, 0, 32'h40);
    step(1, 0, 1, 0, 0, 32'h80);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 32'h60);

    // Coroutine swap, return through the swapped entry, return with flush, flush during stall.
    step(1, 1, 0, 0, 0, 32'h100);
    step(1, 0, 1, 0, 0, 32'h400);
    step(1, 0, 1, 1, 0, 32'h999);
    step(1, 0, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h500);
    step(1, 0, 0, 1, 1, 32'h0);
    step(1, 0, 1, 0, 0, 32'h600);
    step(0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 1, 1, 0, 32'h300);
    seq(1);

    // PC wrap, and return taking priority over redirect.
    step(1, 1, 0, 0, 0, 32'hFFFF_FFFC);
    seq(1);
    step(1, 0, 1, 0, 0, 32'h800);
    step(1, 1, 0, 1, 0, 32'h777);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFFC;
      st_nxt = ($urandom_range(0, 99) != 0);
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 19) == 0), rpc);
    end
    st_nxt = 1'b1;
    seq(1);

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
